// File: rtl/token_precision_assigner.sv
// token_precision_assigner: sums per-token attention columns over all rows and heads,
// then maps each token's score to an INT4/INT8/FP16 precision code.
module token_precision_assigner #(
   parameter int DATA_WIDTH = 16,
   parameter int L = 8,
   parameter int N = 1,
   parameter int THR_INT8 = 256,
   parameter int THR_FP16 = 1024,
   localparam int SW = DATA_WIDTH + $clog2(L*N)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [DATA_WIDTH*L*N*L-1:0]  A_in,
   output logic [3:0]                   token_precision [L-1:0],
   output logic [SW*L-1:0]              score_out,
   output logic                         done,
   output logic                         out_valid
);
   localparam int RW = (L > 1) ? $clog2(L) : 1;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACCUM, S_CLASSIFY, S_DONE} state_t;
   state_t                        state_q;
   logic [RW-1:0]                 row_q;
   logic [DATA_WIDTH*L*N*L-1:0]   a_q;
   logic [SW-1:0]                 score_q [L];
   logic [SW-1:0]                 row_sum_d [L];
   logic [3:0]                    tp_q [L-1:0];
   logic [SW*L-1:0]               so_q;
   logic                          done_q, valid_q;
   logic                          last_row_d;
   assign last_row_d = (row_q == RW'(L-1));
   always_comb begin
      for (int j = 0; j < L; j++) begin
         row_sum_d[j] = '0;
         for (int n = 0; n < N; n++)
            row_sum_d[j] = row_sum_d[j] + SW'(a_q[((int'(row_q)*N + n)*L + j)*DATA_WIDTH +: DATA_WIDTH]);
      end
   end
   // done/out_valid are registered in S_DONE, so they pulse on the cycle after it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         score_q <= '{default: '0};
         tp_q    <= '{default: '0};
         so_q    <= '0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: state_q <= start ? S_LOAD : S_IDLE;
            S_LOAD: begin
               a_q     <= A_in;
               score_q <= '{default: '0};
               row_q   <= '0;
               state_q <= S_ACCUM;
            end
            S_ACCUM: begin
               for (int j = 0; j < L; j++) score_q[j] <= score_q[j] + row_sum_d[j];
               row_q   <= last_row_d ? '0 : row_q + 1'b1;
               state_q <= last_row_d ? S_CLASSIFY : S_ACCUM;
            end
            S_CLASSIFY: begin
               for (int j = 0; j < L; j++) begin
                  tp_q[j] <= (64'(score_q[j]) >= 64'(THR_FP16)) ? 4'd2 :
                             (64'(score_q[j]) >= 64'(THR_INT8)) ? 4'd1 : 4'd0;
                  so_q[j*SW +: SW] <= score_q[j];
               end
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b1;
               valid_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign token_precision = tp_q;
   assign score_out       = so_q;
   assign done            = done_q;
   assign out_valid       = valid_q;
endmodule

// File: tb/tb_token_precision_assigner.sv
// tb_token_precision_assigner: directed and random runs checked against a column-sum
// reference model of the precision classifier.
module tb_token_precision_assigner;
   localparam int DW = 16, L = 4, N = 1, T8 = 256, T16 = 1024;
   localparam int SW = DW + $clog2(L*N);
   localparam int AW = DW*L*N*L;
   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [AW-1:0] A_in = '0;
   logic [3:0]    token_precision [L-1:0];
   logic [SW*L-1:0] score_out;
   logic          done, out_valid;
   int            total = 0, passed = 0, fails = 0;
   logic [DW-1:0] m [L][L];

   token_precision_assigner #(.DATA_WIDTH(DW), .L(L), .N(N), .THR_INT8(T8), .THR_FP16(T16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A_in(A_in),
      .token_precision(token_precision), .score_out(score_out),
      .done(done), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] pack();
      logic [AW-1:0] v = '0;
      for (int l = 0; l < L; l++)
         for (int j = 0; j < L; j++) v[(l*L + j)*DW +: DW] = m[l][j];
      return v;
   endfunction

   task automatic check_results(input string tag);
      for (int j = 0; j < L; j++) begin
         longint s = 0;
         int code;
         for (int l = 0; l < L; l++) s += m[l][j];
         code = (s >= T16) ? 2 : (s >= T8) ? 1 : 0;
         chk($sformatf("%s score%0d", tag, j), 64'(score_out[j*SW +: SW]), s);
         chk($sformatf("%s code%0d", tag, j), 64'(token_precision[j]), 64'(code));
      end
   endtask

   task automatic run(input string tag);
      int n = 0;
      A_in = pack();
      start = 1'b1;
      tick();
      start = 1'b0;
      while (done !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'(L + 3));
      chk({tag, " out_valid"}, 64'(out_valid), 64'(done));
      tick();
      chk({tag, " done_pulse_width"}, 64'(done), 64'd0);
      check_results(tag);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, " score_out"}, 64'(score_out), 64'd0);
      for (int j = 0; j < L; j++) chk($sformatf("%s code%0d", tag, j), 64'(token_precision[j]), 64'd0);
      chk({tag, " done"}, 64'(done), 64'd0);
      chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      int nd;
      tick();
      tick();
      check_zero_outputs("reset");
      rst_n = 1'b1;
      tick();

      for (int l = 0; l < L; l++) for (int j = 0; j < L; j++) m[l][j] = '0;
      run("zero");

      for (int l = 0; l < L; l++) for (int j = 0; j < L; j++) m[l][j] = DW'(128*j);
      run("ramp");

      for (int l = 0; l < L; l++) for (int j = 0; j < L; j++) m[l][j] = 16'hFFFF;
      run("max");

      for (int r = 0; r < 4; r++) begin
         for (int l = 0; l < L; l++) for (int j = 0; j < L; j++) m[l][j] = DW'($urandom_range(0, 700));
         run($sformatf("rand%0d", r));
      end

      // start retriggered mid-run and A_in changed after capture
      for (int l = 0; l < L; l++) for (int j = 0; j < L; j++) m[l][j] = DW'($urandom_range(0, 900));
      A_in = pack();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      A_in = {8{$urandom()}};
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      nd = 0;
      for (int e = 4; e < 20; e++) begin
         tick();
         if (done === 1'b1) begin
            chk("ignore_start done_edge", 64'(e), 64'(L + 3));
            nd++;
         end
      end
      chk("ignore_start done_count", 64'(nd), 64'd1);
      check_results("ignore_start");

      // reset during the second accumulation cycle
      for (int l = 0; l < L; l++) for (int j = 0; j < L; j++) m[l][j] = DW'(128*j);
      A_in = pack();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      nd = 0;
      for (int e = 0; e < 12; e++) begin
         if (done === 1'b1) nd++;
         tick();
      end
      chk("abort done_count", 64'(nd), 64'd0);
      check_zero_outputs("abort");
      run("after_abort");

      // start held high: back-to-back runs
      start = 1'b1;
      for (int e = 0; e < 20; e++) begin
         tick();
         chk($sformatf("b2b done@%0d", e), 64'(done),
             64'((e >= L + 3) && ((e - (L + 3)) % (L + 4) == 0)));
         chk($sformatf("b2b valid@%0d", e), 64'(out_valid), 64'(done));
      end
      start = 1'b0;
      for (int e = 0; e < 12; e++) tick();
      check_results("b2b");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
